// File: rtl/synth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : synth_pkg
// Description : Shared constants and FSM state type for the voice allocator.
// Revision    : 1.0 - initial release
// ============================================================================
package synth_pkg;

    localparam int         NBANKS_DEFAULT = 10;
    localparam logic [6:0] MIDI_IDLE      = 7'h00;
    localparam logic [3:0] AGE_MAX        = 4'd15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MATCH  = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/voice_slot_search.sv
`default_nettype none
// ============================================================================
// Module      : voice_slot_search
// Description : Combinational slot search: note hits, lowest free slot and
//               oldest occupied slot (ties resolve to the lowest index).
// Revision    : 1.0 - initial release
// ============================================================================
module voice_slot_search
    import synth_pkg::*;
#(
    parameter int NBANKS = NBANKS_DEFAULT
) (
    input  logic [NBANKS-1:0][6:0] i_notes,
    input  logic [NBANKS-1:0][3:0] i_ages,
    input  logic [6:0]             i_query,
    output logic [NBANKS-1:0]      o_hit,
    output logic [3:0]             o_free_idx,
    output logic                   o_free_valid,
    output logic [3:0]             o_oldest_idx
);

    logic [3:0] w_best_age;
    logic       w_found;

    always_comb begin
        o_hit        = '0;
        o_free_idx   = '0;
        o_free_valid = 1'b0;
        o_oldest_idx = '0;
        w_best_age   = '0;
        w_found      = 1'b0;
        for (int i = 0; i < NBANKS; i++) begin
            o_hit[i] = (i_notes[i] == i_query);
            if (i_notes[i] == MIDI_IDLE) begin
                if (!o_free_valid) begin
                    o_free_valid = 1'b1;
                    o_free_idx   = 4'(i);
                end
            // strict compare keeps the lowest index on equal ages
            end else if (!w_found || (i_ages[i] > w_best_age)) begin
                w_found      = 1'b1;
                w_best_age   = i_ages[i];
                o_oldest_idx = 4'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
// Module      : voice_allocator
// Description : Polyphonic voice allocator with round-robin note stream.
//               Define VOICE_STEAL_EN to steal the oldest slot when full.
// Revision    : 1.0 - initial release
// ============================================================================
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NBANKS = NBANKS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       i_valid,
    input  logic       i_note_on,
    input  logic [6:0] i_note,
    output logic       o_ready,
    output logic [6:0] o_midi,
    output logic [3:0] o_slot,
    output logic [3:0] o_voices,
    output logic       o_drop,
    output logic       o_steal
);

`ifdef VOICE_STEAL_EN
    localparam bit c_STEAL_EN = 1'b1;
`else
    localparam bit c_STEAL_EN = 1'b0;
`endif

    state_t                  state_q, state_d;
    logic                    ev_on_q, ev_on_d;
    logic [6:0]              ev_note_q, ev_note_d;
    logic [NBANKS-1:0]       hit_q, hit_d;
    logic [3:0]              free_idx_q, free_idx_d;
    logic                    free_valid_q, free_valid_d;
    logic [3:0]              oldest_idx_q, oldest_idx_d;
    logic [NBANKS-1:0][6:0]  notes_q, notes_d;
    logic [NBANKS-1:0][3:0]  ages_q, ages_d;
    logic [3:0]              ptr_q, ptr_d;
    logic [6:0]              midi_q, midi_d;
    logic [3:0]              slot_q, slot_d;
    logic [3:0]              voices_q, voices_d;
    logic                    drop_q, drop_d;
    logic                    steal_q, steal_d;

    logic [NBANKS-1:0]       w_hit;
    logic [3:0]              w_free_idx;
    logic                    w_free_valid;
    logic [3:0]              w_oldest_idx;
    logic [3:0]              w_victim;
    logic                    w_write;

    voice_slot_search #(.NBANKS(NBANKS)) u_search (
        .i_notes      (notes_q),
        .i_ages       (ages_q),
        .i_query      (ev_note_q),
        .o_hit        (w_hit),
        .o_free_idx   (w_free_idx),
        .o_free_valid (w_free_valid),
        .o_oldest_idx (w_oldest_idx)
    );

    always_comb begin
        state_d      = state_q;
        ev_on_d      = ev_on_q;
        ev_note_d    = ev_note_q;
        hit_d        = hit_q;
        free_idx_d   = free_idx_q;
        free_valid_d = free_valid_q;
        oldest_idx_d = oldest_idx_q;
        notes_d      = notes_q;
        ages_d       = ages_q;
        ptr_d        = ptr_q;
        midi_d       = midi_q;
        slot_d       = slot_q;
        voices_d     = voices_q;
        drop_d       = 1'b0;
        steal_d      = 1'b0;
        w_write      = 1'b0;
        w_victim     = free_valid_q ? free_idx_q : oldest_idx_q;

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    ev_on_d   = i_note_on;
                    ev_note_d = i_note;
                    state_d   = MATCH;
                end
            end
            MATCH: begin
                hit_d        = w_hit;
                free_idx_d   = w_free_idx;
                free_valid_d = w_free_valid;
                oldest_idx_d = w_oldest_idx;
                state_d      = COMMIT;
            end
            COMMIT: begin
                state_d = IDLE;
                if (ev_note_q == MIDI_IDLE) begin
                    drop_d = 1'b1;
                end else if (ev_on_q) begin
                    // an already-held note is left alone (no retrigger)
                    if (hit_q == '0) begin
                        if (free_valid_q || c_STEAL_EN) begin
                            w_write = 1'b1;
                            steal_d = !free_valid_q;
                        end else begin
                            drop_d = 1'b1;
                        end
                    end
                end else begin
                    for (int i = 0; i < NBANKS; i++) begin
                        if (hit_q[i]) begin
                            notes_d[i] = MIDI_IDLE;
                            ages_d[i]  = '0;
                        end
                    end
                end
                if (w_write) begin
                    for (int i = 0; i < NBANKS; i++) begin
                        if (4'(i) == w_victim) begin
                            notes_d[i] = ev_note_q;
                            ages_d[i]  = '0;
                        end else if ((notes_q[i] != MIDI_IDLE) && (ages_q[i] != AGE_MAX)) begin
                            ages_d[i] = ages_q[i] + 4'd1;
                        end
                    end
                end
                voices_d = '0;
                for (int i = 0; i < NBANKS; i++) begin
                    voices_d = voices_d + 4'(notes_d[i] != MIDI_IDLE);
                end
            end
            default: state_d = IDLE;
        endcase

        // stream reads the pre-commit table; a same-cycle write shows next frame
        if (clk_en) begin
            midi_d = notes_q[ptr_q];
            slot_d = ptr_q;
            ptr_d  = (ptr_q == 4'(NBANKS - 1)) ? 4'd0 : ptr_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ev_on_q      <= 1'b0;
            ev_note_q    <= MIDI_IDLE;
            hit_q        <= '0;
            free_idx_q   <= '0;
            free_valid_q <= 1'b0;
            oldest_idx_q <= '0;
            notes_q      <= '0;
            ages_q       <= '0;
            ptr_q        <= '0;
            midi_q       <= MIDI_IDLE;
            slot_q       <= '0;
            voices_q     <= '0;
            drop_q       <= 1'b0;
            steal_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ev_on_q      <= ev_on_d;
            ev_note_q    <= ev_note_d;
            hit_q        <= hit_d;
            free_idx_q   <= free_idx_d;
            free_valid_q <= free_valid_d;
            oldest_idx_q <= oldest_idx_d;
            notes_q      <= notes_d;
            ages_q       <= ages_d;
            ptr_q        <= ptr_d;
            midi_q       <= midi_d;
            slot_q       <= slot_d;
            voices_q     <= voices_d;
            drop_q       <= drop_d;
            steal_q      <= steal_d;
        end
    end

    assign o_ready  = (state_q == IDLE);
    assign o_midi   = midi_q;
    assign o_slot   = slot_q;
    assign o_voices = voices_q;
    assign o_drop   = drop_q;
    assign o_steal  = steal_q;

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// ============================================================================
// Module      : tb_voice_allocator
// Description : Scoreboard bench for voice_allocator with a behavioural
//               slot-table model and randomized note events.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_voice_allocator;

    localparam int NB = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_en = 1'b0;
    logic       i_valid = 1'b0;
    logic       i_note_on = 1'b0;
    logic [6:0] i_note = '0;
    logic       o_ready;
    logic [6:0] o_midi;
    logic [3:0] o_slot;
    logic [3:0] o_voices;
    logic       o_drop;
    logic       o_steal;

    voice_allocator #(.NBANKS(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .i_valid   (i_valid),
        .i_note_on (i_note_on),
        .i_note    (i_note),
        .o_ready   (o_ready),
        .o_midi    (o_midi),
        .o_slot    (o_slot),
        .o_voices  (o_voices),
        .o_drop    (o_drop),
        .o_steal   (o_steal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // committed model table, and the table an in-flight event will produce
    int mnote[NB];
    int mage[NB];
    int pn[NB];
    int pa[NB];

    typedef struct {
        bit drop;
        bit steal;
        int voices;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    bit en_all = 1'b1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Spec rules applied to an array table
    task automatic model_event(input bit on, input int note,
                               output bit drop, output bit steal, output int voices);
        int slot = -1;
        int held = -1;
        pn = mnote;
        pa = mage;
        drop = 1'b0;
        steal = 1'b0;
        if (note == 0) begin
            drop = 1'b1;
        end else if (on) begin
            for (int j = 0; j < NB; j++) if (pn[j] == note) held = j;
            if (held < 0) begin
                for (int j = NB - 1; j >= 0; j--) if (pn[j] == 0) slot = j;
                if (slot < 0) begin
`ifdef VOICE_STEAL_EN
                    int oldest = 0;
                    for (int j = 1; j < NB; j++) if (pa[j] > pa[oldest]) oldest = j;
                    slot = oldest;
                    steal = 1'b1;
`else
                    drop = 1'b1;
`endif
                end
                if (slot >= 0) begin
                    for (int j = 0; j < NB; j++)
                        if (j != slot && pn[j] != 0) pa[j] = (pa[j] < 15) ? pa[j] + 1 : 15;
                    pn[slot] = note;
                    pa[slot] = 0;
                end
            end
        end else begin
            for (int j = 0; j < NB; j++) if (pn[j] == note) begin pn[j] = 0; pa[j] = 0; end
        end
        voices = 0;
        for (int j = 0; j < NB; j++) if (pn[j] != 0) voices++;
    endtask

    // Called at a falling edge; returns at the falling edge of the commit-visible cycle.
    task automatic send(input bit on, input int note);
        bit d, s;
        int v;
        int budget = 0;
        while (!o_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!o_ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        i_valid = 1'b1;
        i_note_on = on;
        i_note = 7'(note);
        @(negedge clk);
        i_valid = 1'b0;
        model_event(on, note, d, s, v);
        sb.push_back('{drop: d, steal: s, voices: v});
        @(negedge clk);
        @(negedge clk);
        mnote = pn;
        mage = pa;
    endtask

    task automatic clear_model();
        for (int j = 0; j < NB; j++) begin
            mnote[j] = 0;
            mage[j] = 0;
        end
    endtask

    // sample strobe generator
    initial begin
        forever begin
            @(negedge clk);
            clk_en = en_all ? 1'b1 : ($urandom_range(0, 2) == 0);
        end
    end

    // stream monitor: expected emission captured at the strobe edge
    int  bptr = 0;
    bit  pend = 1'b0;
    int  exp_midi = 0;
    int  exp_slot = 0;
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                bptr = 0;
                pend = 1'b0;
            end else if (clk_en) begin
                exp_midi = mnote[bptr];
                exp_slot = bptr;
                bptr = (bptr + 1) % NB;
                pend = 1'b1;
            end else begin
                pend = 1'b0;
            end
        end
    end
    initial begin
        forever begin
            @(negedge clk);
            if (pend && !rst) begin
                check("stream_midi", int'(o_midi), exp_midi);
                check("stream_slot", int'(o_slot), exp_slot);
            end
        end
    end

    // completion monitor: o_ready returning high marks a committed event
    bit prev_rdy = 1'b1;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_rdy = 1'b1;
            end else begin
                if (o_ready && !prev_rdy) begin
                    if (sb.size() == 0) begin
                        check("unexpected_completion", 1, 0);
                    end else begin
                        mon_e = sb.pop_front();
                        check("drop", int'(o_drop), int'(mon_e.drop));
                        check("steal", int'(o_steal), int'(mon_e.steal));
                        check("voices", int'(o_voices), mon_e.voices);
                    end
                end else begin
                    check("no_stray_pulse", int'({o_drop, o_steal}), 0);
                end
                prev_rdy = o_ready;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        pn = mnote;
        pa = mage;
        repeat (3) @(negedge clk);
        check("rst_ready", int'(o_ready), 1);
        check("rst_midi", int'(o_midi), 0);
        check("rst_slot", int'(o_slot), 0);
        check("rst_voices", int'(o_voices), 0);
        check("rst_pulses", int'({o_drop, o_steal}), 0);
        rst = 1'b0;
        repeat (13) @(negedge clk);

        send(1, 60); send(1, 64); send(1, 67);
        repeat (12) @(negedge clk);
        check("voices_three", int'(o_voices), 3);
        send(0, 64); send(1, 72); send(0, 99);
        repeat (12) @(negedge clk);
        check("voices_reuse", int'(o_voices), 3);

        send(0, 60); send(0, 67); send(0, 72);
        for (int n = 50; n < 60; n++) send(1, n);
        check("voices_full", int'(o_voices), 10);
        send(1, 80);
        repeat (12) @(negedge clk);
        send(1, 0);
        send(1, 60); send(1, 60);
        check("voices_still_full", int'(o_voices), 10);
        repeat (12) @(negedge clk);

        en_all = 1'b0;
        for (int k = 0; k < 150; k++) begin
            int note;
            note = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(40, 55));
            send(1'($urandom_range(0, 1)), note);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        repeat (40) @(negedge clk);

        // reset while the note-on 70 sits in MATCH
        en_all = 1'b1;
        @(negedge clk);
        i_valid = 1'b1;
        i_note_on = 1'b1;
        i_note = 7'd70;
        @(negedge clk);
        i_valid = 1'b0;
        #2;
        rst = 1'b1;
        clear_model();
        #1;
        check("midrst_ready", int'(o_ready), 1);
        check("midrst_voices", int'(o_voices), 0);
        check("midrst_midi", int'(o_midi), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        check("post_rst_voices", int'(o_voices), 0);
        send(1, 61);
        repeat (12) @(negedge clk);
        check("post_rst_one_voice", int'(o_voices), 1);

        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
